vga_timing_pipeline: RTL
========================

# vga_timing_pipeline

Generates the 640x480@60 Hz VGA raster for the sprite display path. It drives `counter_H`/`counter_V` into the frame-buffer stage and consumes that stage's 1-bit `colour` a fixed number of cycles later. It delays sync and blanking to match that latency, then registers blanked 2-bit-per-channel RGB plus hsync/vsync to the pins. It also provides a frame-start strobe and a free-running frame counter for sprite animation.

## Interface

**Parameters**
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal porches and sync width, in clocks.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical porches and sync width, in lines.
- `PIPE_DELAY`, 2: clocks from counters to a valid `colour` input. Legal range 0..4.

**Ports**
- `clk` in 1: pixel clock, 25.175 MHz nominal.
- `reset` in 1: asynchronous, active-low.
- `colour` in 1: pixel from the frame-buffer stage. 1 = white, 0 = black.
- `counter_H` out 10: horizontal position, 0..H_TOTAL-1.
- `counter_V` out 10: vertical position, 0..V_TOTAL-1.
- `frame_start` out 1: high while `counter_H`==0 and `counter_V`==0.
- `frame_count` out 6: frames completed, mod 64.
- `hsync` out 1: registered, active-low.
- `vsync` out 1: registered, active-low.
- `R`, `G`, `B` out 2 each: registered pixel channels.

## Operation

**Totals**
- H_TOTAL = sum of the H parameters (800).
- V_TOTAL = sum of the V parameters (525).
- Both fit in 10 bits; the arithmetic is unsigned 10-bit.

**Counters**
- `counter_H` increments every clock.
- When `counter_H`==H_TOTAL-1: `counter_H` wraps to 0 and `counter_V` increments.
- When `counter_V`==V_TOTAL-1 at the same time: `counter_V` wraps to 0 and `frame_count` increments, wrapping 63 to 0.

**Raw decode** (combinational from the counters)
- hs_raw = 0 iff H_ACTIVE+H_FP ≤ `counter_H` < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs_raw = 0 iff V_ACTIVE+V_FP ≤ `counter_V` < V_ACTIVE+V_FP+V_SYNC (490..491).
- de_raw = (`counter_H` < H_ACTIVE) && (`counter_V` < V_ACTIVE).

**Delay line**
- {hs, vs, de} pass through a PIPE_DELAY-stage shift register.
- PIPE_DELAY=0 means a direct connection.

**Output register** (every clock)
- `hsync` ← delayed hs; `vsync` ← delayed vs.
- `R`, `G`, `B` ← {2{`colour`}} when delayed de = 1, else 2'b00.

**`frame_start`**
- Combinational decode of the registered counters; not delayed.

## Timing

**Reset** (async, takes effect immediately, mid-frame included)
- `counter_H` = `counter_V` = 0, `frame_count` = 0.
- Delay stages hold hs=1, vs=1, de=0.
- `hsync` = `vsync` = 1; `R`/`G`/`B` = 0.
- `frame_start` = 1, since the counters are 0,0.
- First increment on the first rising edge after release.

**Latency**
- Counter value at edge t appears on `hsync`/`vsync`/RGB after edge t+PIPE_DELAY+1.
- `colour` must correspond to the counters of PIPE_DELAY cycles earlier.

**Fixed periods**
- Line = 800 clocks.
- Frame = 420 000 clocks.
- `hsync` low for exactly H_SYNC consecutive clocks per line.
- `vsync` low for exactly V_SYNC×H_TOTAL clocks per frame.

**Boundary cases**
- Simultaneous H and V wrap: a single edge takes the counters to 0,0 and increments `frame_count`.
- Active region: `colour` is ignored outside it; RGB forced to 0.

## Configuration

`VGA_CHECKER_EN`
- **Defined:** `colour` is ignored.
  - A checker bit = bit0 of (`counter_H`/40 + `counter_V`/40) is computed from the raw counters.
  - It is delayed through an extra bit in the delay line, so alignment is identical.
  - It drives RGB in place of `colour` (1 = white). Used for bring-up of a 40-pixel tile grid.
- **Undefined:** checker logic is absent; `colour` drives RGB as above.

## Test plan

1. **Reset release.** Hold `reset`=0 for 5 clocks, then release.
   - During reset: `hsync`=`vsync`=1, RGB=0, counters 0,0, `frame_start`=1.
   - 800 clocks after release: `counter_H`=0, `counter_V`=1.
2. **Hsync, PIPE_DELAY=2.**
   - `hsync` falls exactly 3 clocks after `counter_H` becomes 656.
   - It stays low for 96 clocks and recurs every 800 clocks.
3. **Frame.** Run 420 000 clocks.
   - `vsync` low for 1600 clocks, starting 3 clocks after `counter_V`=490, `counter_H`=0.
   - `frame_count` 0→1 exactly at the 0,0 wrap.
   - `frame_start` high for 1 clock per frame.
4. **Blanking.** Hold `colour`=1.
   - RGB = 6'b111111 from 3 clocks after `counter_H`=0 through 3 clocks after `counter_H`=639, on lines 0..479.
   - RGB = 0 at all other times, including all of lines 480..524.
5. **Mid-frame reset.** Assert `reset`=0 at `counter_H`=300, `counter_V`=200.
   - Outputs go inactive with no clock edge.
   - After release, the counters restart at 0,0 and `frame_count`=0.
6. **`VGA_CHECKER_EN` defined, `colour` held 0.**
   - Counter position (0,0): RGB=0 three clocks later.
   - Counter position (40,0): RGB=6'b111111.
   - Counter position (40,40): RGB=0.

Source files
------------

// File: rtl/vga_timing_pipeline.sv
// vga_timing_pipeline: 640x480@60 raster generator for the sprite display path.
// Emits counter_H/counter_V to the frame-buffer stage, takes its 1-bit colour
// PIPE_DELAY clocks later, and registers blanked RGB plus sync to the pins.
// Build option: define VGA_CHECKER_EN to replace colour with a 40-pixel checker
// tile pattern for bring-up.
module vga_timing_pipeline #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       colour,
    output logic [9:0] counter_H,
    output logic [9:0] counter_V,
    output logic       frame_start,
    output logic [5:0] frame_count,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    // Delay-line vector: bit0 hs, bit1 vs, bit2 de, bit3 checker (when built in).
`ifdef VGA_CHECKER_EN
    localparam int W = 4;
`else
    localparam int W = 3;
`endif
    // Idle value held in every stage during reset: syncs high, blanked.
    localparam logic [W-1:0] IDLE_VEC = {{(W-2){1'b0}}, 2'b11};

    logic [W-1:0] raw_vec;
    logic [W-1:0] dly_vec;
    logic         hs_raw;
    logic         vs_raw;
    logic         de_raw;
    logic         pix_bit;

    // Raster counters; H and V wrap together on the last pixel of a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_H   <= '0;
            counter_V   <= '0;
            frame_count <= '0;
        end else if (counter_H == H_LAST) begin
            counter_H <= '0;
            if (counter_V == V_LAST) begin
                counter_V   <= '0;
                frame_count <= frame_count + 6'd1;
            end else begin
                counter_V <= counter_V + 10'd1;
            end
        end else begin
            counter_H <= counter_H + 10'd1;
        end
    end

    // Raw sync/blank decode straight from the counters.
    always_comb begin
        hs_raw = !((counter_H >= HS_START) && (counter_H < HS_END));
        vs_raw = !((counter_V >= VS_START) && (counter_V < VS_END));
        de_raw = (counter_H < H_VIS) && (counter_V < V_VIS);
    end

    assign frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);

`ifdef VGA_CHECKER_EN
    logic [9:0] tile_sum;
    assign tile_sum = (counter_H / 10'd40) + (counter_V / 10'd40);
    assign raw_vec  = {tile_sum[0], de_raw, vs_raw, hs_raw};
    // colour is masked off: the checker bit travels the delay line instead.
    assign pix_bit  = dly_vec[3] | (colour & 1'b0);
`else
    assign raw_vec  = {de_raw, vs_raw, hs_raw};
    assign pix_bit  = colour;
`endif

    generate
        if (PIPE_DELAY == 0) begin : g_direct
            assign dly_vec = raw_vec;
        end else begin : g_pipe
            logic [W-1:0] stage [PIPE_DELAY];

            // Shift register matching the frame-buffer stage latency.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= IDLE_VEC;
                end else begin
                    stage[0] <= raw_vec;
                    for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
                end
            end

            assign dly_vec = stage[PIPE_DELAY-1];
        end
    endgenerate

    // Pin register: delayed sync, RGB forced black outside the active region.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            R     <= 2'b00;
            G     <= 2'b00;
            B     <= 2'b00;
        end else begin
            hsync <= dly_vec[0];
            vsync <= dly_vec[1];
            R     <= dly_vec[2] ? {2{pix_bit}} : 2'b00;
            G     <= dly_vec[2] ? {2{pix_bit}} : 2'b00;
            B     <= dly_vec[2] ? {2{pix_bit}} : 2'b00;
        end
    end

endmodule
